// File: rtl/phys_free_list_pkg.sv
// Shared rename-stage types: architectural register count, physical register index and the
// commit-side release record.
package phys_free_list_pkg;

  localparam int unsigned ARCH_REGS = 32;

  typedef logic [5:0] pr_idx_t;

  typedef struct packed {
    logic    valid;
    pr_idx_t pr;
  } fl_push_t;

endpackage

// File: rtl/fl_compact.sv
// Prefix count over per-lane valids: each lane gets the number of valid lanes below it, which
// is its write offset from the tail, and npush is the total.
module fl_compact
  import phys_free_list_pkg::*;
#(
  parameter int unsigned SS = 2,
  localparam int unsigned CW = $clog2(SS + 1)
) (
  input  logic [SS-1:0]         valid,
  output logic [SS-1:0][CW-1:0] offset,
  output logic [CW-1:0]         npush
);

  logic [CW-1:0] run;

  always_comb begin
    run    = '0;
    offset = '0;
    for (int i = 0; i < SS; i++) begin
      offset[i] = run;
      run       = run + CW'(valid[i]);
    end
    npush = run;
  end

endmodule

// File: rtl/phys_free_list.sv
// Circular FIFO of free physical registers: SS-wide all-or-nothing pops toward rename,
// per-lane compacted pushes from commit, sticky overflow flag when a release is dropped.
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int unsigned SS         = 2,
  parameter int unsigned PR_ENTRIES = 64,
  parameter int unsigned ARCH_REGS  = 32,
  parameter int unsigned FL_DEPTH   = PR_ENTRIES - ARCH_REGS,
  localparam int unsigned PR_W      = $clog2(PR_ENTRIES),
  localparam int unsigned CNT_W     = $clog2(FL_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pop,
  output logic [SS-1:0][PR_W-1:0] free_list_regs,
  output logic                    fl_avail,
  input  logic [SS-1:0]           push_valid,
  input  logic [SS-1:0][PR_W-1:0] push_reg,
  output logic [CNT_W-1:0]        fl_count,
  output logic                    overflow_err
);

  localparam int unsigned PTR_W = $clog2(FL_DEPTH);
  localparam int unsigned CW    = $clog2(SS + 1);

  if ((FL_DEPTH & (FL_DEPTH - 1)) != 0 || FL_DEPTH < SS) begin : g_depth_check
    $error("phys_free_list: FL_DEPTH must be a power of two and at least SS");
  end

  logic [PR_W-1:0]  mem_q [FL_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  fl_push_t [SS-1:0]         lane;
  logic [SS-1:0]             lane_valid;
  logic [SS-1:0]             lane_accept;
  logic [SS-1:0][CW-1:0]     lane_offset;
  logic [CW-1:0]             npush;
  logic                      do_pop;
  logic                      drop;
  int unsigned               remain;
  int unsigned               room;
  int unsigned               n_acc;

  // p0 is hardwired x0, so a release of register 0 is never a real free entry.
  always_comb begin
    for (int i = 0; i < SS; i++) begin
      lane[i].valid = push_valid[i] && (push_reg[i] != '0);
      lane[i].pr    = pr_idx_t'(push_reg[i]);
      lane_valid[i] = lane[i].valid;
    end
  end

  fl_compact #(
    .SS(SS)
  ) u_compact (
    .valid (lane_valid),
    .offset(lane_offset),
    .npush (npush)
  );

  assign do_pop = pop && fl_avail;

  // Lanes beyond the room left after this cycle's pop are dropped, highest lane first.
  always_comb begin
    remain      = 32'(count_q) - (do_pop ? SS : 32'd0);
    room        = FL_DEPTH - remain;
    n_acc       = 0;
    lane_accept = '0;
    for (int i = 0; i < SS; i++) begin
      lane_accept[i] = lane_valid[i] && (32'(lane_offset[i]) < room);
      n_acc          = n_acc + 32'(lane_accept[i]);
    end
    drop = 32'(npush) > room;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= PR_W'(ARCH_REGS + i);
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= CNT_W'(FL_DEPTH);
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < SS; i++) begin
        if (lane_accept[i]) begin
          mem_q[tail_q + PTR_W'(lane_offset[i])] <= PR_W'(lane[i].pr);
        end
      end
      if (do_pop) begin
        head_q <= head_q + PTR_W'(SS);
      end
      tail_q  <= tail_q + PTR_W'(n_acc);
      count_q <= CNT_W'(remain + n_acc);
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SS; i++) begin
      free_list_regs[i] = (CNT_W'(i) < count_q) ? mem_q[head_q + PTR_W'(i)] : '0;
    end
  end

  assign fl_avail     = count_q >= CNT_W'(SS);
  assign fl_count     = count_q;
  assign overflow_err = overflow_q;

  // Commit should never release more registers than the list can hold.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst) !drop)
    else $warning("phys_free_list: release dropped, free list already full");

endmodule
